// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one word fetch at a time, answers after
// LATENCY wait states, and exposes a write-only load port for preloading the image.
module imem_responder #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned           LATENCY    = 1,
    parameter logic [31:0]           NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_instr_o,
    output logic                  rsp_err_o,
    input  logic                  load_en_i,
    input  logic [DEPTH_LOG2-1:0] load_addr_i,
    input  logic [31:0]           load_data_i
);

    localparam logic [ADDR_WIDTH-1:0] SPAN    = ADDR_WIDTH'(4) << DEPTH_LOG2;
    localparam logic [3:0]            LAT_CNT = 4'(LATENCY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             instr_q;
    logic                    err_q;

    logic [31:0]             mem [0:(2**DEPTH_LOG2)-1];

    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [DEPTH_LOG2-1:0]   rd_idx;
    logic                    rd_err;
    logic                    enter_resp;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    cnt_d   = LAT_CNT;
                    state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states RESP is entered straight from IDLE, so the
    // lookup must use the live request address instead of the captured one.
    always_comb begin
        rd_addr    = (state_q == S_IDLE) ? req_addr_i : addr_q;
        offset     = rd_addr - BASE_ADDR;
        rd_idx     = offset[DEPTH_LOG2+1:2];
        rd_err     = (rd_addr[1:0] != 2'b00) || (offset >= SPAN);
        enter_resp = (state_q != S_RESP) && (state_d == S_RESP);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            instr_q <= NOP_INSTR;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            if (enter_resp) begin
                err_q   <= rd_err;
                instr_q <= rd_err ? NOP_INSTR : mem[rd_idx];
            end
        end
    end

    // Non-blocking write gives read-before-write on a same-edge collision.
    always_ff @(posedge clk_i) begin
        if (load_en_i) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    assign rsp_instr_o = instr_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances with LATENCY 1, 0 and 4
// share clock and reset; stimulus and sampling happen 1ns after each rising edge.
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [31:0] req_addr  [3];
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_ready;
    logic [31:0] rsp_instr [3];
    logic [2:0]  rsp_err;
    logic [2:0]  load_en;
    logic [9:0]  load_addr [3];
    logic [31:0] load_data [3];

    int n_checks;
    int n_errors;
    int lat_of [3] = '{1, 0, 4};

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imem_responder #(
            .LATENCY(g == 0 ? 1 : (g == 1 ? 0 : 4))
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_addr_i  (req_addr[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready[g]),
            .rsp_instr_o (rsp_instr[g]),
            .rsp_err_o   (rsp_err[g]),
            .load_en_i   (load_en[g]),
            .load_addr_i (load_addr[g]),
            .load_data_i (load_data[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [9:0] idx, input logic [31:0] data);
        load_en[i]   = 1'b1;
        load_addr[i] = idx;
        load_data[i] = data;
        tick();
        load_en[i]   = 1'b0;
    endtask

    // Presents one request, waits (bounded) for the response, then completes
    // the handshake. Returns the cycle count from acceptance to rsp_valid.
    task automatic fetch(input int i, input logic [31:0] addr,
                         output logic [31:0] instr, output logic err, output int cyc);
        req_valid[i] = 1'b1;
        req_addr[i]  = addr;
        rsp_ready[i] = 1'b1;
        tick();
        req_valid[i] = 1'b0;
        cyc = 1;
        while (!rsp_valid[i] && cyc < 40) begin
            tick();
            cyc++;
        end
        if (!rsp_valid[i]) check("rsp_timeout", 32'(rsp_valid[i]), 32'd1);
        instr = rsp_instr[i];
        err   = rsp_err[i];
        tick();
        check("rsp_valid_after_hs", 32'(rsp_valid[i]), 32'd0);
    endtask

    initial begin
        logic [31:0] instr;
        logic        err;
        int          cyc;

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req_valid = 'x;
        rsp_ready = 'x;
        load_en   = '0;
        for (int i = 0; i < 3; i++) begin
            req_addr[i]  = '0;
            load_addr[i] = '0;
            load_data[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        req_valid = '0;
        rsp_ready = '1;
        #3 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 3; i++) begin
            check("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check("reset_rsp_err",   32'(rsp_err[i]),   32'd0);
            check("reset_rsp_instr", rsp_instr[i],      NOP);
            check("reset_req_ready", 32'(req_ready[i]), 32'd1);
        end

        // Basic fetch, LATENCY=1, cycle-by-cycle
        load(0, 10'd0, 32'h0010_0093);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h8000_0000;
        check("l1_ready_N", 32'(req_ready[0]), 32'd1);
        tick();
        req_valid[0] = 1'b0;
        check("l1_valid_N1", 32'(rsp_valid[0]), 32'd0);
        check("l1_ready_N1", 32'(req_ready[0]), 32'd0);
        tick();
        check("l1_valid_N2", 32'(rsp_valid[0]), 32'd1);
        check("l1_instr_N2", rsp_instr[0],      32'h0010_0093);
        check("l1_err_N2",   32'(rsp_err[0]),   32'd0);
        check("l1_ready_N2", 32'(req_ready[0]), 32'd0);
        tick();
        check("l1_valid_N3", 32'(rsp_valid[0]), 32'd0);
        check("l1_ready_N3", 32'(req_ready[0]), 32'd1);
        check("l1_hold_N3",  rsp_instr[0],      32'h0010_0093);

        // LATENCY=0 back-to-back, request held high through RESP
        load(1, 10'd1, 32'hAAAA_0001);
        load(1, 10'd2, 32'hBBBB_0002);
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h8000_0004;
        check("l0_ready_A", 32'(req_ready[1]), 32'd1);
        tick();
        req_addr[1] = 32'h8000_0008;
        check("l0_valid_A1", 32'(rsp_valid[1]), 32'd1);
        check("l0_instr_A1", rsp_instr[1],      32'hAAAA_0001);
        check("l0_ready_A1", 32'(req_ready[1]), 32'd0);
        tick();
        check("l0_valid_A2", 32'(rsp_valid[1]), 32'd0);
        check("l0_ready_A2", 32'(req_ready[1]), 32'd1);
        tick();
        req_valid[1] = 1'b0;
        check("l0_valid_A3", 32'(rsp_valid[1]), 32'd1);
        check("l0_instr_A3", rsp_instr[1],      32'hBBBB_0002);
        check("l0_err_A3",   32'(rsp_err[1]),   32'd0);
        tick();
        check("l0_valid_A4", 32'(rsp_valid[1]), 32'd0);

        // Backpressure with a blocked request and a load to the held word
        load(0, 10'd5, 32'h5555_0005);
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h8000_0014;
        tick();
        req_valid[0] = 1'b0;
        tick();
        check("bp_valid", 32'(rsp_valid[0]), 32'd1);
        check("bp_instr", rsp_instr[0],      32'h5555_0005);
        for (int k = 0; k < 5; k++) begin
            req_valid[0] = 1'b1;
            req_addr[0]  = 32'h8000_0000;
            if (k == 1) begin
                load_en[0]   = 1'b1;
                load_addr[0] = 10'd5;
                load_data[0] = 32'hFFFF_0000;
            end
            tick();
            load_en[0] = 1'b0;
            check("bp_hold_valid", 32'(rsp_valid[0]), 32'd1);
            check("bp_hold_instr", rsp_instr[0],      32'h5555_0005);
            check("bp_hold_err",   32'(rsp_err[0]),   32'd0);
            check("bp_hold_ready", 32'(req_ready[0]), 32'd0);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        tick();
        check("bp_release", 32'(rsp_valid[0]), 32'd0);
        tick();
        check("bp_no_stale", 32'(rsp_valid[0]), 32'd0);
        fetch(0, 32'h8000_0014, instr, err, cyc);
        check("bp_newdata", instr, 32'hFFFF_0000);

        // Error responses and the last in-range word
        load(0, 10'd1023, 32'hCAFE_03FF);
        fetch(0, 32'h8000_0002, instr, err, cyc);
        check("err_misalign_err",   32'(err), 32'd1);
        check("err_misalign_instr", instr,    NOP);
        fetch(0, 32'h7FFF_FFFC, instr, err, cyc);
        check("err_below_err",   32'(err), 32'd1);
        check("err_below_instr", instr,    NOP);
        fetch(0, 32'h8000_1000, instr, err, cyc);
        check("err_above_err",   32'(err), 32'd1);
        check("err_above_instr", instr,    NOP);
        fetch(0, 32'h8000_0FFC, instr, err, cyc);
        check("last_word_err",   32'(err), 32'd0);
        check("last_word_instr", instr,    32'hCAFE_03FF);
        check("l1_cycles",       32'(cyc), 32'(lat_of[0] + 1));

        // Collision: write on the RESP-entry edge returns old data
        load(0, 10'd3, 32'hDEAD_BEEF);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h8000_000C;
        tick();
        req_valid[0] = 1'b0;
        load_en[0]   = 1'b1;
        load_addr[0] = 10'd3;
        load_data[0] = 32'h1234_5678;
        tick();
        load_en[0] = 1'b0;
        check("col_valid", 32'(rsp_valid[0]), 32'd1);
        check("col_old",   rsp_instr[0],      32'hDEAD_BEEF);
        tick();
        fetch(0, 32'h8000_000C, instr, err, cyc);
        check("col_new", instr, 32'h1234_5678);

        // LATENCY=0 latency through the generic fetch
        fetch(1, 32'h8000_0008, instr, err, cyc);
        check("l0_cycles", 32'(cyc), 32'(lat_of[1] + 1));
        check("l0_instr",  instr,    32'hBBBB_0002);

        // LATENCY=4, then reset mid-WAIT
        load(2, 10'd7, 32'h7777_7777);
        fetch(2, 32'h8000_001C, instr, err, cyc);
        check("l4_cycles", 32'(cyc), 32'(lat_of[2] + 1));
        check("l4_instr",  instr,    32'h7777_7777);
        req_valid[2] = 1'b1;
        req_addr[2]  = 32'h8000_001C;
        tick();
        req_valid[2] = 1'b0;
        tick();
        check("rst_pre_wait", 32'(req_ready[2]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(rsp_valid[2]), 32'd0);
        check("rst_async_ready", 32'(req_ready[2]), 32'd1);
        check("rst_async_instr", rsp_instr[2],      NOP);
        check("rst_async_err",   32'(rsp_err[2]),   32'd0);
        #10 rst_n = 1'b1;
        tick();
        begin
            int seen = 0;
            for (int k = 0; k < 10; k++) begin
                if (rsp_valid[2]) seen++;
                tick();
            end
            check("rst_no_rsp", 32'(seen), 32'd0);
        end
        fetch(2, 32'h8000_001C, instr, err, cyc);
        check("rst_after_instr",  instr,    32'h7777_7777);
        check("rst_after_err",    32'(err), 32'd0);
        check("rst_after_cycles", 32'(cyc), 32'(lat_of[2] + 1));
        fetch(0, 32'h8000_0000, instr, err, cyc);
        check("rst_mem_intact", instr, 32'h0010_0093);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
